// File: rtl/sat_pkg.sv
// Shared clause types and dispatch-mode constants for the BCP front end.
package sat_pkg;
   localparam int DEF_CLAUSE_WIDTH = 4;
   localparam int DEF_ELEMENT_CNT  = 1024;

   // A literal is a variable index plus a sign bit.
   function automatic int lit_bits(input int element_cnt);
      return $clog2(element_cnt) + 1;
   endfunction

   localparam int DEF_LIT_BITS = lit_bits(DEF_ELEMENT_CNT);

   typedef logic [DEF_LIT_BITS-1:0]  lit_t;
   typedef lit_t [DEF_CLAUSE_WIDTH-1:0] clause_t;

   localparam int MODE_RR    = 0;
   localparam int MODE_FIXED = 1;
endpackage

// File: rtl/clause_dispatcher_if.sv
// Source-side handshake and engine-side grant bus of the clause dispatcher.
interface clause_dispatcher_if #(
   parameter int N_ENG = 4,
   parameter int CW    = 44
);
   logic             in_valid;
   logic [CW-1:0]    in_clause;
   logic             in_ready;
   logic [N_ENG-1:0] eng_full;
   logic [N_ENG-1:0] grant_out;
   logic [CW-1:0]    clause_out;

   modport master (output in_valid, in_clause, eng_full,
                   input  in_ready, grant_out, clause_out);
   modport slave  (input  in_valid, in_clause, eng_full,
                   output in_ready, grant_out, clause_out);
endinterface

// File: rtl/clause_fifo.sv
// Clause queue: DEPTH entries, pointers wrap naturally, full/empty from occupancy.
module clause_fifo #(
   parameter int W     = 44,
   parameter int DEPTH = 8
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           wdata,
   output logic [W-1:0]           head,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic          do_push, do_pop;

   assign full    = (occupancy == (AW+1)'(DEPTH));
   assign empty   = (occupancy == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

   // Flush dominates any simultaneous push or pop.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else if (flush) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         occupancy <= occupancy + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/clause_dispatcher.sv
// Buffers incoming clauses and hands each head clause to one non-full BCP engine
// per cycle, round-robin or fixed priority, as a registered one-cycle pulse.
module clause_dispatcher
   import sat_pkg::*;
#(
   parameter int N_ENG        = 4,
   parameter int CLAUSE_WIDTH = DEF_CLAUSE_WIDTH,
   parameter int ELEMENT_CNT  = DEF_ELEMENT_CNT,
   parameter int LIT_BITS     = lit_bits(ELEMENT_CNT),
   parameter int DEPTH        = 8,
   parameter int MODE         = MODE_RR
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   flush,
   clause_dispatcher_if.slave     bus,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic [15:0]            stall_cnt
);
   localparam int CW = CLAUSE_WIDTH * LIT_BITS;

   logic [CW-1:0]    head, clause_q;
   logic [N_ENG-1:0] req, pick, base, grant_q;
   logic             full, empty, push;

   // Double-request subtract: lowest requester at or above base, wrapping.
   function automatic logic [N_ENG-1:0] pick_fn(input logic [N_ENG-1:0] r,
                                                input logic [N_ENG-1:0] b);
      logic [2*N_ENG-1:0] dbl, dif;
      dbl = {r, r};
      dif = dbl & ~(dbl - {{N_ENG{1'b0}}, b});
      if (MODE == MODE_FIXED) return r & (~r + 1'b1);
      return dif[N_ENG-1:0] | dif[2*N_ENG-1:N_ENG];
   endfunction

   assign req          = ~bus.eng_full & {N_ENG{!empty}};
   assign pick         = pick_fn(req, base);
   assign push         = bus.in_valid && !full;
   assign bus.in_ready = !full;
   assign bus.grant_out  = grant_q;
   assign bus.clause_out = clause_q;

   clause_fifo #(.W(CW), .DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (flush),
      .push      (push),
      .pop       (|pick),
      .wdata     (bus.in_clause),
      .head      (head),
      .occupancy (occupancy),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         grant_q   <= '0;
         clause_q  <= '0;
         base      <= {{(N_ENG-1){1'b0}}, 1'b1};
         stall_cnt <= '0;
      end else begin
         if (!empty && !(|req) && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
         // A flush drops the decision made this cycle; base is kept.
         if (flush) begin
            grant_q <= '0;
         end else begin
            grant_q <= pick;
            if (|pick) begin
               clause_q <= head;
               base     <= {pick[N_ENG-2:0], pick[N_ENG-1]};
            end
         end
      end
   end
endmodule

// File: tb/tb_clause_dispatcher.sv
// Drives a round-robin and a fixed-priority dispatcher with the same stimulus and
// compares both against a queue-based reference model.
module tb_clause_dispatcher;
   import sat_pkg::*;

   localparam int N     = 4;
   localparam int CW    = $bits(clause_t);
   localparam int DEPTH = 8;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic [CW-1:0] in_clause = '0;
   logic [N-1:0]  eng_full = '0;
   logic [3:0]    occ0, occ1;
   logic [15:0]   st0, st1;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   clause_dispatcher_if #(.N_ENG(N), .CW(CW)) b0 ();
   clause_dispatcher_if #(.N_ENG(N), .CW(CW)) b1 ();

   assign b0.in_valid = in_valid;  assign b1.in_valid = in_valid;
   assign b0.in_clause = in_clause; assign b1.in_clause = in_clause;
   assign b0.eng_full = eng_full;  assign b1.eng_full = eng_full;

   clause_dispatcher #(.N_ENG(N), .DEPTH(DEPTH), .MODE(MODE_RR)) d0 (
      .clock(clock), .reset_n(reset_n), .flush(flush), .bus(b0),
      .occupancy(occ0), .stall_cnt(st0));
   clause_dispatcher #(.N_ENG(N), .DEPTH(DEPTH), .MODE(MODE_FIXED)) d1 (
      .clock(clock), .reset_n(reset_n), .flush(flush), .bus(b1),
      .occupancy(occ1), .stall_cnt(st1));

   // Reference model: one queue per mode, integer base index.
   logic [CW-1:0] mq [2][$];
   int            mbase [2];
   logic [N-1:0]  mgrant [2];
   logic [CW-1:0] mclause [2];
   int            mstall [2];

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mq[m].delete();
         mbase[m] = 0; mgrant[m] = '0; mclause[m] = '0; mstall[m] = 0;
      end
   endtask

   task automatic model_edge();
      for (int m = 0; m < 2; m++) begin
         bit acc;
         int j;
         acc = in_valid && (mq[m].size() < DEPTH);
         if (mq[m].size() != 0 && eng_full == '1 && mstall[m] < 65535) mstall[m]++;
         if (flush) begin
            mq[m].delete();
            mgrant[m] = '0;
         end else begin
            j = -1;
            if (mq[m].size() > 0)
               for (int k = 0; k < N; k++) begin
                  int idx;
                  idx = (m == 0) ? (mbase[m] + k) % N : k;
                  if (j < 0 && !eng_full[idx]) j = idx;
               end
            if (j >= 0) begin
               mgrant[m]  = N'(1) << j;
               mclause[m] = mq[m].pop_front();
               if (m == 0) mbase[m] = (j + 1) % N;
            end else begin
               mgrant[m] = '0;
            end
            if (acc) mq[m].push_back(in_clause);
         end
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("grant_rr",  64'(b0.grant_out),  64'(mgrant[0]));
      chk("clause_rr", 64'(b0.clause_out), 64'(mclause[0]));
      chk("occ_rr",    64'(occ0),          64'(mq[0].size()));
      chk("ready_rr",  64'(b0.in_ready),   64'(mq[0].size() < DEPTH));
      chk("stall_rr",  64'(st0),           64'(mstall[0]));
      chk("grant_fx",  64'(b1.grant_out),  64'(mgrant[1]));
      chk("clause_fx", 64'(b1.clause_out), 64'(mclause[1]));
      chk("occ_fx",    64'(occ1),          64'(mq[1].size()));
      chk("ready_fx",  64'(b1.in_ready),   64'(mq[1].size() < DEPTH));
      chk("stall_fx",  64'(st1),           64'(mstall[1]));
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      check_all();
   endtask

   function automatic logic [CW-1:0] rnd_clause();
      return CW'({$urandom, $urandom});
   endfunction

   task automatic push_n(input int n, input logic [N-1:0] full_mask);
      eng_full = full_mask;
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1; in_clause = rnd_clause();
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      bit seen;
      model_reset();
      repeat (2) @(posedge clock);
      #1 check_all();
      @(negedge clock) reset_n = 1'b1;
      #4;

      // Round-robin sweep, then two-engine alternation.
      push_n(5, 4'b0000); idle(3);
      push_n(4, 4'b0101); idle(4);

      // Fill to full with every engine busy, then drain through engine 0.
      push_n(9, 4'b1111); idle(2);
      eng_full = 4'b1110; idle(10);

      // Lowest-index priority with and without engine 0.
      push_n(3, 4'b0000); idle(3);
      push_n(3, 4'b0001); idle(3);

      // Flush at occupancy 5 together with a push.
      push_n(5, 4'b1111);
      flush = 1'b1; in_valid = 1'b1; in_clause = rnd_clause();
      tick();
      flush = 1'b0; in_valid = 1'b0;
      eng_full = 4'b0000; idle(2);

      // Random traffic with occasional flush.
      for (int i = 0; i < 300; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_clause = rnd_clause();
         eng_full  = ($urandom_range(0, 3) == 0) ? 4'b1111 : N'($urandom);
         flush     = ($urandom_range(0, 31) == 0);
         tick();
      end
      flush = 1'b0; in_valid = 1'b0; eng_full = 4'b0000; idle(DEPTH + 2);

      // Asynchronous reset while engine 2 is receiving a grant.
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         in_valid = 1'b1; in_clause = rnd_clause();
         tick();
         seen = (b0.grant_out == 4'b0100);
      end
      chk("grant_0100_seen", 64'(seen), 64'(1));
      #1 reset_n = 1'b0;
      #1 model_reset();
      check_all();
      #3 reset_n = 1'b1;
      in_valid = 1'b1; in_clause = rnd_clause();
      tick();
      in_valid = 1'b0;
      tick();
      chk("first_grant_after_reset", 64'(b0.grant_out), 64'(4'b0001));
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/clause_dispatcher.md
Name: clause_dispatcher

Overview:
Buffered, parametrised clause distributor between the clause source and N_ENG BCP engines. Clauses enter through a valid/ready handshake and are queued in a DEPTH-entry FIFO. Each head clause is granted to one non-full engine, chosen round-robin or by fixed priority. The grant and clause outputs are registered one-cycle pulses. The block adds flush, occupancy and stall statistics.

Parameters:
N_ENG, 4, number of engines / grant lines (>=2)
CLAUSE_WIDTH, 4, literals per clause
ELEMENT_CNT, 1024, variable count
LIT_BITS, $clog2(ELEMENT_CNT)+1, bits per literal (sign + index)
DEPTH, 8, FIFO entries (power of 2, >=2)
MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of queued and in-flight clauses
in_valid  in  1  source offers in_clause
in_clause  in  CLAUSE_WIDTH*LIT_BITS  clause payload
in_ready  out  1  FIFO can accept (= !fifo_full)
eng_full  in  N_ENG  engine j cannot accept when bit j is 1
grant_out  out  N_ENG  one-hot (or zero) registered grant pulse
clause_out  out  CLAUSE_WIDTH*LIT_BITS  clause for the engine granted in the same cycle
occupancy  out  $clog2(DEPTH)+1  FIFO entry count
stall_cnt  out  16  saturating count of cycles with FIFO non-empty and all engines full

Behaviour:
- Reset (reset_n=0, async):
  - grant_out=0, clause_out=0, occupancy=0, stall_cnt=0.
  - FIFO rd/wr pointers=0; base=one-hot bit 0.
  - in_ready=1 while the FIFO is empty.
- Push: on in_valid && in_ready. Payload is written at the clock edge and visible at the head the next cycle. There is no bypass path.
- Decision cycle: request = ~eng_full, qualified by FIFO non-empty.
  - MODE 0: pick the first requesting engine at or above base, wrapping modulo N_ENG (double-request subtract trick).
  - MODE 1: pick the lowest-index requester; base is ignored.
- Pop: when a pick exists, pop the head. On the next edge, register grant_out=onehot(pick) and clause_out=head.
  - Otherwise grant_out is registered to 0 and clause_out holds its last value.
- Latency: clause pushed at edge t is dispatched at edge t+1 and appears on grant_out/clause_out during cycle t+1..t+2. Minimum is 2 edges from acceptance.
- grant_out is high for exactly one cycle per clause. One clause per cycle maximum.
- Engines must assert eng_full with at least one entry of slack, because the full bit is sampled one cycle before delivery.
- Base update (MODE 0): after a grant to j, base = onehot((j+1) mod N_ENG). With no grant, base is unchanged.
- Occupancy:
  - Push+pop in the same cycle leaves the count unchanged.
  - Full: in_ready=0. Pop while full raises in_ready the next cycle.
  - Empty: no pick, grant_out=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from occupancy.
- stall_cnt increments when occupancy!=0 && request==0, and saturates at 0xFFFF. Only reset clears it; flush does not.
- Flush:
  - On the next edge: pointers and occupancy go to 0, and grant_out is 0 (in-flight decision dropped).
  - Flush wins over a simultaneous push and pop.
  - base and stall_cnt are retained.
- Reset asserted mid-operation discards all state immediately, including any grant pulse in progress.

Decomposition:
- Package sat_pkg: LIT_BITS function, lit_t, clause_t (CLAUSE_WIDTH x lit_t), MODE_RR/MODE_FIXED constants.
- Sub-module clause_fifo (parametric DEPTH, clause_t storage, push/pop/flush, occupancy).
- The pick logic stays in the top as a function.

Test Plan:
- Reset release, eng_full=0000, push clauses A,B,C,D,E on consecutive cycles (MODE 0) -> grant_out sequence 0001,0010,0100,1000,0001 with clause_out A..E. First grant arrives 2 edges after A is accepted.
- eng_full=0101, push 4 clauses (MODE 0) -> grants alternate 0010,1000,0010,1000. stall_cnt stays 0.
- eng_full=1111, push 9 clauses into DEPTH=8 -> in_ready drops after 8 are accepted, occupancy=8, stall_cnt increments each cycle. Releasing eng_full=1110 -> one grant 0001 per cycle, in_ready=1 one cycle after the first pop.
- MODE 1, eng_full=0000, push 3 clauses -> all grants 0001. With eng_full=0001 -> all grants 0010.
- Occupancy=5, assert flush together with in_valid -> next cycle occupancy=0, grant_out=0, pushed clause discarded, stall_cnt unchanged.
- Drop reset_n mid-stream while grant_out=0100 -> grant_out=0, occupancy=0 immediately. After release, the first grant is 0001.
